// File: rtl/perceptron_weight_loader.sv
// Serialises a parallel (b, W0, W1) weight set MSB-first onto the perceptron's
// bit-serial load port and gates the datapath enable until a full set is loaded.
module perceptron_weight_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] W0_word_i,
    input  logic [WIDTH-1:0] W1_word_i,
    input  logic [WIDTH-1:0] b_word_i,
    input  logic             run_i,
    output logic [1:0]       W1W0b_en_o,
    output logic             b_o,
    output logic             W0_o,
    output logic             W1_o,
    output logic             dp_enable_o,
    output logic             loaded_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_B  = 3'd1,
        ST_SHIFT_W0 = 3'd2,
        ST_SHIFT_W1 = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] w0_sr_q, w0_sr_d;
    logic [WIDTH-1:0] w1_sr_q, w1_sr_d;
    logic [1:0]       en_q, en_d;
    logic             b_q, b_d;
    logic             w0_q, w0_d;
    logic             w1_q, w1_d;
    logic             ready_q, ready_d;
    logic             dp_en_q, dp_en_d;
    logic             loaded_q, loaded_d;
    logic             done_q, done_d;
    logic             accept_s;

    function automatic logic [1:0] sel_code(input state_t s);
        logic [1:0] code;
        case (s)
            ST_SHIFT_B:  code = 2'b01;
            ST_SHIFT_W0: code = 2'b10;
            ST_SHIFT_W1: code = 2'b11;
            default:     code = 2'b00;
        endcase
        return code;
    endfunction

    // Sequence control: capture, per-word shift/count and phase transitions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_sr_d   = b_sr_q;
        w0_sr_d  = w0_sr_q;
        w1_sr_d  = w1_sr_q;
        accept_s = load_valid_i & ready_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    b_sr_d  = b_word_i;
                    w0_sr_d = W0_word_i;
                    w1_sr_d = W1_word_i;
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_B: begin
                b_sr_d = {b_sr_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT_W0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SHIFT_W0: begin
                w0_sr_d = {w0_sr_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT_W1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SHIFT_W1: begin
                w1_sr_d = {w1_sr_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values are decoded from the *next* state so every output is a flop
    always_comb begin
        en_d    = sel_code(state_d);
        b_d     = (state_d == ST_SHIFT_B)  ? b_sr_d[WIDTH-1]  : 1'b0;
        w0_d    = (state_d == ST_SHIFT_W0) ? w0_sr_d[WIDTH-1] : 1'b0;
        w1_d    = (state_d == ST_SHIFT_W1) ? w1_sr_d[WIDTH-1] : 1'b0;
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
        if (accept_s) begin
            loaded_d = 1'b0;
        end else if (state_d == ST_DONE) begin
            loaded_d = 1'b1;
        end else begin
            loaded_d = loaded_q;
        end
        // Accepting edge already starts a load, so enable must not leak into it
        dp_en_d = run_i & loaded_q & (state_q == ST_IDLE) & ~accept_s;
    end

    // State, shift registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            b_sr_q   <= {WIDTH{1'b0}};
            w0_sr_q  <= {WIDTH{1'b0}};
            w1_sr_q  <= {WIDTH{1'b0}};
            en_q     <= 2'b00;
            b_q      <= 1'b0;
            w0_q     <= 1'b0;
            w1_q     <= 1'b0;
            ready_q  <= 1'b1;
            dp_en_q  <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_sr_q   <= b_sr_d;
            w0_sr_q  <= w0_sr_d;
            w1_sr_q  <= w1_sr_d;
            en_q     <= en_d;
            b_q      <= b_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            ready_q  <= ready_d;
            dp_en_q  <= dp_en_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

    assign load_ready_o = ready_q;
    assign W1W0b_en_o   = en_q;
    assign b_o          = b_q;
    assign W0_o         = w0_q;
    assign W1_o         = w1_q;
    assign dp_enable_o  = dp_en_q;
    assign loaded_o     = loaded_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_perceptron_weight_loader.sv
// Self-checking bench: cycle-exact load timing checks plus a scoreboard that
// rebuilds the serialised words the way the datapath would and compares them.
module tb_perceptron_weight_loader;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] w0;
        logic [W-1:0] w1;
    } set_t;

    logic         clk;
    logic         reset;
    logic         load_valid_i;
    logic         load_ready_o;
    logic [W-1:0] W0_word_i;
    logic [W-1:0] W1_word_i;
    logic [W-1:0] b_word_i;
    logic         run_i;
    logic [1:0]   W1W0b_en_o;
    logic         b_o;
    logic         W0_o;
    logic         W1_o;
    logic         dp_enable_o;
    logic         loaded_o;
    logic         done_o;

    int total = 0;
    int bad   = 0;
    set_t sb_q[$];

    perceptron_weight_loader #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .W0_word_i    (W0_word_i),
        .W1_word_i    (W1_word_i),
        .b_word_i     (b_word_i),
        .run_i        (run_i),
        .W1W0b_en_o   (W1W0b_en_o),
        .b_o          (b_o),
        .W0_o         (W0_o),
        .W1_o         (W1_o),
        .dp_enable_o  (dp_enable_o),
        .loaded_o     (loaded_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sign of W0*X0 + W1*X1 + b with X0 = X1 = 1 (true when negative)
    function automatic bit neg_decision(input set_t s);
        int sum;
        sum = int'($signed(s.w0)) + int'($signed(s.w1)) + int'($signed(s.b));
        return (sum < 0);
    endfunction

    // Datapath stand-in: rebuild each serial word and check it against the scoreboard
    set_t rec;
    int   nb, nw0, nw1;
    initial begin
        rec = '0; nb = 0; nw0 = 0; nw1 = 0;
    end
    always @(negedge clk) begin
        if (reset) begin
            rec = '0; nb = 0; nw0 = 0; nw1 = 0;
        end else begin
            case (W1W0b_en_o)
                2'b01: begin
                    rec.b = {rec.b[W-2:0], b_o}; nb++;
                    chk("mon_idle_w_in_b", {W0_o, W1_o}, 2'b00);
                end
                2'b10: begin
                    rec.w0 = {rec.w0[W-2:0], W0_o}; nw0++;
                    chk("mon_idle_w_in_w0", {b_o, W1_o}, 2'b00);
                end
                2'b11: begin
                    rec.w1 = {rec.w1[W-2:0], W1_o}; nw1++;
                    chk("mon_idle_w_in_w1", {b_o, W0_o}, 2'b00);
                end
                default: chk("mon_serial_idle", {b_o, W0_o, W1_o}, 3'b000);
            endcase
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    set_t e;
                    e = sb_q.pop_front();
                    chk("sb_b",  rec.b,  e.b);
                    chk("sb_w0", rec.w0, e.w0);
                    chk("sb_w1", rec.w1, e.w1);
                    chk("sb_bitcounts", {nb[7:0], nw0[7:0], nw1[7:0]}, {8'(W), 8'(W), 8'(W)});
                    chk("sb_sign", neg_decision(rec), neg_decision(e));
                end
                rec = '0; nb = 0; nw0 = 0; nw1 = 0;
            end
        end
    end

    // Offer a set, accept it at the next edge, then check every busy cycle exactly
    task automatic run_load(input set_t s, input bit keep_valid, input set_t nxt, input bit toggle_run);
        logic [1:0] code;
        logic       eb, ew0, ew1;
        chk("ready_pre", load_ready_o, 1'b1);
        load_valid_i = 1'b1;
        b_word_i = s.b; W0_word_i = s.w0; W1_word_i = s.w1;
        @(posedge clk); #1;
        sb_q.push_back(s);
        load_valid_i = keep_valid;
        for (int k = 1; k <= 3*W+2; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (keep_valid) begin
                if (k == 3*W+2) begin
                    b_word_i = nxt.b; W0_word_i = nxt.w0; W1_word_i = nxt.w1;
                end else begin
                    b_word_i = W'($urandom); W0_word_i = W'($urandom); W1_word_i = W'($urandom);
                end
            end
            if (toggle_run) run_i = (k <= 3*W) ? k[0] : 1'b1;
            code = 2'b00; eb = 1'b0; ew0 = 1'b0; ew1 = 1'b0;
            if (k <= W) begin
                code = 2'b01; eb = s.b[W-k];
            end else if (k <= 2*W) begin
                code = 2'b10; ew0 = s.w0[2*W-k];
            end else if (k <= 3*W) begin
                code = 2'b11; ew1 = s.w1[3*W-k];
            end
            chk("sel_code", W1W0b_en_o, code);
            chk("bit_b",  b_o,  eb);
            chk("bit_w0", W0_o, ew0);
            chk("bit_w1", W1_o, ew1);
            chk("done",   done_o, (k == 3*W+1));
            chk("ready",  load_ready_o, (k == 3*W+2));
            chk("loaded", loaded_o, (k >= 3*W+1));
            chk("dp_en_busy", dp_enable_o, 1'b0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, load_ready_o, 1'b1);
        chk({tag, "_code"},  W1W0b_en_o, 2'b00);
        chk({tag, "_ser"},   {b_o, W0_o, W1_o}, 3'b000);
        chk({tag, "_dpen"},  dp_enable_o, 1'b0);
        chk({tag, "_loaded"}, loaded_o, 1'b0);
        chk({tag, "_done"},  done_o, 1'b0);
    endtask

    initial begin
        set_t s_basic, s_rel, s_a, s_b, s_fresh, s_ext, s_none;
        s_basic = '{b: 8'h81, w0: 8'h7F, w1: 8'hC3};
        s_rel   = '{b: 8'h5A, w0: 8'hA5, w1: 8'h3C};
        s_a     = '{b: 8'h12, w0: 8'h34, w1: 8'h56};
        s_b     = '{b: 8'hE7, w0: 8'h09, w1: 8'hB2};
        s_fresh = '{b: 8'h3F, w0: 8'hC0, w1: 8'h01};
        s_ext   = '{b: 8'h80, w0: 8'h00, w1: 8'hFF};
        s_none  = '0;

        reset = 1'b1; load_valid_i = 1'b0; run_i = 1'b1;
        b_word_i = '0; W0_word_i = '0; W1_word_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("pre_load_dpen", dp_enable_o, 1'b0);
        end

        // basic load with run held high, then gating opens one cycle after IDLE
        run_load(s_basic, 1'b0, s_none, 1'b0);
        @(posedge clk); #1;
        chk("dpen_first", dp_enable_o, 1'b1);
        @(posedge clk); #1;
        chk("dpen_hold", dp_enable_o, 1'b1);

        // reload with run toggling during the load
        run_load(s_rel, 1'b0, s_none, 1'b1);
        @(posedge clk); #1;
        chk("dpen_after_reload", dp_enable_o, 1'b1);

        // backpressure: valid held with changing words, set B taken in first IDLE cycle
        run_load(s_a, 1'b1, s_b, 1'b0);
        run_load(s_b, 1'b0, s_none, 1'b0);
        @(posedge clk); #1;
        chk("dpen_after_bp", dp_enable_o, 1'b1);

        // run low closes the gate; loaded persists
        run_i = 1'b0;
        @(posedge clk); #1;
        chk("dpen_run_off", dp_enable_o, 1'b0);
        chk("loaded_persist", loaded_o, 1'b1);
        run_i = 1'b1;
        @(posedge clk); #1;
        chk("dpen_run_on", dp_enable_o, 1'b1);

        // reset in cycle 12 of a load (SHIFT_W0)
        load_valid_i = 1'b1;
        b_word_i = 8'hAA; W0_word_i = 8'h55; W1_word_i = 8'hF0;
        @(posedge clk); #1;
        load_valid_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_code_w0", W1W0b_en_o, 2'b10);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("postrst");
        run_load(s_fresh, 1'b0, s_none, 1'b0);
        @(posedge clk); #1;
        chk("dpen_after_fresh", dp_enable_o, 1'b1);

        // signed extremes
        run_load(s_ext, 1'b0, s_none, 1'b0);
        @(posedge clk); #1;
        chk("dpen_after_ext", dp_enable_o, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/perceptron_weight_loader.md
# perceptron_weight_loader

Upstream feeder for the perceptron datapath. Accepts a parallel weight set (W0, W1, b) over a valid/ready handshake, then serialises each word MSB-first onto the datapath's bit-serial weight/bias load port with the matching select code. It also gates the datapath `enable` so the datapath only computes on a completely loaded weight set. Total load time is 3·WIDTH+1 cycles.

## Interface
- `WIDTH`, default 8: weight/bias word width. Must match the datapath `WIDTH`; WIDTH ≥ 2.
- `clk` input 1: rising-edge clock, shared with the datapath.
- `reset` input 1: asynchronous, active-high. The datapath's own reset is active-low synchronous; the top level drives it with `~reset`.
- `load_valid_i` input 1: parallel weight set present.
- `load_ready_o` output 1: loader can accept a set.
- `W0_word_i` input WIDTH: W0 value, two's complement.
- `W1_word_i` input WIDTH: W1 value.
- `b_word_i` input WIDTH: bias value.
- `run_i` input 1: request for datapath computation.
- `W1W0b_en_o` output 2: select code to the datapath. 01 = b, 10 = W0, 11 = W1, 00 = idle.
- `b_o`, `W0_o`, `W1_o` output 1 each: serial data bits.
- `dp_enable_o` output 1: datapath `enable`.
- `loaded_o` output 1: a complete weight set resides in the datapath.
- `done_o` output 1: one-cycle pulse when a load completes.

## Operation
- FSM states: IDLE, SHIFT_B, SHIFT_W0, SHIFT_W1, DONE.
- **IDLE**
  - `load_ready_o` = 1.
  - On `load_valid_i` & `load_ready_o`, capture all three words into internal shift registers.
  - Clear `loaded_o`, load bit counter = WIDTH−1, go to SHIFT_B.
- **SHIFT_B**
  - `W1W0b_en_o` = 01; `b_o` = current MSB of the b shift register.
  - Each cycle: shift left one bit, decrement the counter.
  - When the counter = 0, reload WIDTH−1 and go to SHIFT_W0.
- **SHIFT_W0**: same behaviour with code 10 on `W0_o`, then go to SHIFT_W1.
- **SHIFT_W1**: same behaviour with code 11 on `W1_o`, then go to DONE.
- **DONE**
  - `W1W0b_en_o` = 00, `done_o` = 1, set `loaded_o`.
  - Next cycle go to IDLE.
- Bit order: bit WIDTH−1 first, bit 0 last. After WIDTH shifts the datapath register holds the exact word.
- Inactive serial outputs are held 0. The active one carries data only in its own state.
- `load_ready_o` = 1 only in IDLE. Inputs offered in any other state are ignored, not queued.
- `dp_enable_o` = `run_i` & `loaded_o` & (state == IDLE), registered.
  - Forced 0 during any load and in DONE.
  - Never asserted after reset until the first load completes.
- `loaded_o` stays set across any number of computations. It clears only on reset or on acceptance of a new set.
- All outputs are driven directly from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `load_ready_o` = 1, `W1W0b_en_o` = 00, `b_o` = `W0_o` = `W1_o` = 0, `dp_enable_o` = 0, `loaded_o` = 0, `done_o` = 0, counter = 0.
- Handshake at edge T0:
  - cycles T0+1 … T0+WIDTH: code 01;
  - T0+WIDTH+1 … T0+2·WIDTH: code 10;
  - T0+2·WIDTH+1 … T0+3·WIDTH: code 11;
  - T0+3·WIDTH+1: `done_o` = 1 and `loaded_o` rises;
  - T0+3·WIDTH+2: IDLE, ready = 1.
- Earliest `dp_enable_o`: the cycle after returning to IDLE with `run_i` high.
- Back-to-back loads: if `load_valid_i` is held high, the next set is accepted in the first IDLE cycle. No DONE→SHIFT shortcut exists.
- Reset asserted mid-load: all outputs return to reset values immediately. The datapath is reset in the same cycles, so no partial weights survive.
- `run_i` toggling during a load has no effect.

## Test plan
- **Basic load**, WIDTH=8, b=0x81, W0=0x7F, W1=0xC3, valid for one cycle:
  - 8 cycles of code 01 with `b_o` = 1,0,0,0,0,0,0,1;
  - 8 cycles of code 10 with `W0_o` = 0,1,1,1,1,1,1,1;
  - 8 cycles of code 11 with `W1_o` = 1,1,0,0,0,0,1,1;
  - `done_o` pulses in cycle 25;
  - reconstructed words match, and the other serial outputs stay 0 throughout.
- **Gating**: `run_i` = 1 from reset:
  - `dp_enable_o` = 0 until one cycle after return to IDLE, then 1;
  - a new load drops it to 0 for all 26 busy cycles.
- **Backpressure**: `load_valid_i` held high with changing words during a load:
  - `load_ready_o` = 0 throughout;
  - the words present in the first IDLE cycle are accepted, and intermediate values are ignored.
- **Reset mid-load**: assert `reset` in cycle 12 (during SHIFT_W0):
  - outputs go to reset values immediately, `loaded_o` = 0;
  - after release, a fresh load completes normally.
- **Reload**: after a completed load, accept a second set:
  - `loaded_o` falls in the cycle after acceptance and rises again with `done_o`;
  - datapath weights equal the second set.
- **Signed extremes**: b=0x80, W0=0x00, W1=0xFF:
  - bitstreams are exact;
  - the end-to-end datapath sign decision matches a reference model for X0=X1=0x01.
